// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store port over a 16-bit asynchronous SRAM
// Each access is split into a low and a high halfword phase, and each phase is held for HALF_CYCLES clocks.
module sram_controller #(
  parameter int HALF_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = $clog2(HALF_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_data;
  logic          lat_wr;
  logic [31:0]   offset;
  logic          half_end;
  logic          unused_offset_bits;

  assign half_end = (cnt == LAST);
  // Data memory starts at byte address 1024; only bits [18:2] of the offset select the word.
  assign offset = lat_addr - 32'd1024;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_wr    <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en || rd_en) begin
            lat_addr <= address;
            lat_data <= write_data;
            lat_wr   <= wr_en;
            cnt      <= '0;
            state    <= LOW;
          end
        end
        LOW: begin
          if (half_end) begin
            cnt   <= '0;
            state <= HIGH;
            if (!lat_wr) read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HIGH: begin
          if (half_end) begin
            cnt   <= '0;
            state <= DONE;
            if (!lat_wr) read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ready       = (state == DONE) || ((state == IDLE) && !wr_en && !rd_en);
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state == LOW || state == HIGH) begin
      sram_addr = {offset[18:2], state == HIGH};
      if (lat_wr) begin
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
        sram_dq_out = (state == HIGH) ? lat_data[31:16] : lat_data[15:0];
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller
// A default build and a HALF_CYCLES=1 build share a small SRAM model.
module tb_sram_controller;

  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        wr_en_b, rd_en_b;
  logic [31:0] address_b, write_data_b, read_data_b;
  logic        ready_b;
  logic [17:0] sram_addr_b;
  logic [15:0] sram_dq_out_b, sram_dq_in_b;
  logic        sram_dq_oe_b, sram_we_n_b;

  logic [15:0] mem [0:15];
  logic [33:0] wq [$];
  logic [31:0] rq [$];
  logic [31:0] rq_b [$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_controller #(.HALF_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  sram_controller #(.HALF_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .rd_en(rd_en_b), .address(address_b),
    .write_data(write_data_b), .read_data(read_data_b), .ready(ready_b),
    .sram_addr(sram_addr_b), .sram_dq_out(sram_dq_out_b), .sram_dq_oe(sram_dq_oe_b),
    .sram_dq_in(sram_dq_in_b), .sram_we_n(sram_we_n_b)
  );

  always @(posedge clk) if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq_out;
  assign sram_dq_in   = mem[sram_addr[3:0]];
  assign sram_dq_in_b = mem[sram_addr_b[3:0]];

  task automatic run_access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd_before, off, exp_rd;
    logic [17:0] ea;
    logic [33:0] ent;
    off = a - 32'd1024;
    if (w) begin
      for (int i = 0; i < 2*H; i++)
        wq.push_back({off[18:2], (i >= H), (i >= H) ? d[31:16] : d[15:0]});
    end else begin
      rq.push_back(d);
    end
    @(posedge clk); #1;
    rd_before = read_data;
    wr_en = w; rd_en = r; address = a; write_data = d;
    for (int c = 0; c <= 2*H+1; c++) begin
      @(negedge clk);
      tests++;
      if (ready !== (c == 2*H+1)) begin
        fails++; $display("FAIL ready_cyc%0d addr=%h: got %b expected %b", c, a, ready, (c == 2*H+1));
      end
      if (c >= 1 && c <= 2*H) begin
        ea = {off[18:2], (c > H)};
        tests++;
        if (sram_addr !== ea) begin
          fails++; $display("FAIL sram_addr_cyc%0d: got %h expected %h", c, sram_addr, ea);
        end
        tests++;
        if (sram_we_n !== !w || sram_dq_oe !== w) begin
          fails++; $display("FAIL strobes_cyc%0d: got we_n=%b oe=%b expected we_n=%b oe=%b", c, sram_we_n, sram_dq_oe, !w, w);
        end
        if (w) begin
          tests++;
          if (wq.size() == 0) begin
            fails++; $display("FAIL write_sb_empty_cyc%0d: got addr=%h dq=%h expected no write", c, sram_addr, sram_dq_out);
          end else begin
            ent = wq.pop_front();
            if ({sram_addr, sram_dq_out} !== ent) begin
              fails++; $display("FAIL write_sb_cyc%0d: got addr=%h dq=%h expected addr=%h dq=%h", c, sram_addr, sram_dq_out, ent[33:16], ent[15:0]);
            end
          end
        end
      end else begin
        tests++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'd0 || sram_dq_out !== 16'd0) begin
          fails++; $display("FAIL idle_outputs_cyc%0d: got we_n=%b oe=%b addr=%h dq=%h expected 1 0 0 0", c, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out);
        end
      end
      if (c == 2*H+1) begin
        if (w) exp_rd = rd_before;
        else exp_rd = rq.pop_front();
        tests++;
        if (read_data !== exp_rd) begin
          fails++; $display("FAIL read_data_done addr=%h: got %h expected %h", a, read_data, exp_rd);
        end
      end
      if (c < 2*H+1) begin
        @(posedge clk); #1;
        address = $urandom; write_data = $urandom;
      end
    end
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    @(negedge clk);
    tests++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
      fails++; $display("FAIL after_done: got ready=%b we_n=%b expected 1 1", ready, sram_we_n);
    end
    tests++;
    if (wq.size() != 0) begin
      fails++; $display("FAIL write_sb_leftover: got %0d entries expected 0", wq.size());
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'd0 ||
        sram_dq_out !== 16'd0 || read_data !== 32'd0 || read_data_b !== 32'd0) begin
      fails++; $display("FAIL reset_state: got ready=%b we_n=%b oe=%b addr=%h dq=%h rd=%h expected 1 1 0 0 0 0",
                        ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, read_data);
    end
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
        fails++; $display("FAIL idle_cyc%0d: got ready=%b we_n=%b oe=%b expected 1 1 0", i, ready, sram_we_n, sram_dq_oe);
      end
    end
  endtask

  task automatic test_write;
    run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
  endtask

  task automatic test_read;
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
  endtask

  task automatic test_write_priority;
    run_access(1'b1, 1'b1, 32'd1028, 32'h12345678);
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    wr_en = 1; address = 32'd1032; write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #3;
    tests++;
    if (sram_we_n !== 1'b0) begin
      fails++; $display("FAIL mid_write_active: got we_n=%b expected 0", sram_we_n);
    end
    rst = 0;
    #1;
    tests++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'd0 || sram_dq_out !== 16'd0 || read_data !== 32'd0) begin
      fails++; $display("FAIL async_abort: got we_n=%b oe=%b addr=%h dq=%h rd=%h expected 1 0 0 0 0",
                        sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, read_data);
    end
    wr_en = 0;
    #1;
    tests++;
    if (ready !== 1'b1) begin
      fails++; $display("FAIL reset_idle_ready: got %b expected 1", ready);
    end
    @(posedge clk); #1;
    rst = 1;
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_rd;
    logic [17:0] exp_addr;
    rq_b.push_back(32'hDEADBEEF);
    rq_b.push_back(32'h12345678);
    @(posedge clk); #1;
    rd_en_b = 1; address_b = 32'd1024;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c <= 3; c++) begin
        @(negedge clk);
        tests++;
        if (ready_b !== (c == 3)) begin
          fails++; $display("FAIL b2b_ready_k%0d_cyc%0d: got %b expected %b", k, c, ready_b, (c == 3));
        end
        if (c == 1 || c == 2) begin
          exp_addr = 18'(2*k + c - 1);
          tests++;
          if (sram_addr_b !== exp_addr || sram_we_n_b !== 1'b1 || sram_dq_oe_b !== 1'b0) begin
            fails++; $display("FAIL b2b_addr_k%0d_cyc%0d: got addr=%h we_n=%b oe=%b expected addr=%h 1 0",
                              k, c, sram_addr_b, sram_we_n_b, sram_dq_oe_b, exp_addr);
          end
        end
        if (c == 3) begin
          exp_rd = rq_b.pop_front();
          tests++;
          if (read_data_b !== exp_rd) begin
            fails++; $display("FAIL b2b_read_k%0d: got %h expected %h", k, read_data_b, exp_rd);
          end
        end
        @(posedge clk); #1;
        if (c == 3) address_b = 32'd1028;
      end
    end
    rd_en_b = 0;
    @(negedge clk);
    tests++;
    if (ready_b !== 1'b1 || sram_addr_b !== 18'd0) begin
      fails++; $display("FAIL b2b_after: got ready=%b addr=%h expected 1 0", ready_b, sram_addr_b);
    end
  endtask

  initial begin
    rst = 0;
    wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    wr_en_b = 0; rd_en_b = 0; address_b = 0; write_data_b = 0;
    repeat (2) @(posedge clk);
    test_reset;
    @(posedge clk); #1;
    rst = 1;
    test_idle;
    test_write;
    test_read;
    test_write_priority;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter HALF_CYCLES, default 2, meaning SRAM cycles held per 16-bit half-access (legal 1..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low: rst=0 resets immediately, independent of clk.
REQ-004 SHALL have port wr_en  input  1  MEM-stage write request (store).
REQ-005 SHALL have port rd_en  input  1  MEM-stage read request (load).
REQ-006 SHALL have port address  input  32  byte address from ALU result.
REQ-007 SHALL have port write_data  input  32  store data (val_rm).
REQ-008 SHALL have port read_data  output  32  load result, registered.
REQ-009 SHALL have port ready  output  1  1 = no stall; 0 = pipeline must freeze.
REQ-010 SHALL have port sram_addr  output  18  SRAM halfword address.
REQ-011 SHALL have port sram_dq_out  output  16  SRAM write data.
REQ-012 SHALL have port sram_dq_oe  output  1  1 = controller drives SRAM data bus.
REQ-013 SHALL have port sram_dq_in  input  16  SRAM read data.
REQ-014 SHALL have port sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-015 SHALL implement FSM states IDLE, LOW, HIGH, DONE with a counter of width ceil(log2(HALF_CYCLES))+1.
REQ-016 IDLE: if wr_en or rd_en is 1, SHALL latch address, write_data, and op (write if wr_en=1, else read), clear counter, and go to LOW; else stay in IDLE.
REQ-017 wr_en=1 and rd_en=1 in the same cycle SHALL be treated as a write.
REQ-018 Address map: offset = (address - 1024) mod 2^32; SHALL drive sram_addr = {offset[18:2], half}, with half=0 in LOW and half=1 in HIGH.
REQ-019 LOW and HIGH SHALL each last exactly HALF_CYCLES cycles; counter increments each cycle and advances state when it equals HALF_CYCLES-1 (LOW->HIGH, HIGH->DONE).
REQ-020 Write, LOW/HIGH: SHALL drive sram_dq_out = data[15:0] (LOW) or data[31:16] (HIGH), with sram_dq_oe=1 and sram_we_n=0 on every cycle of the half.
REQ-021 Read, LOW/HIGH: SHALL hold sram_dq_oe=0 and sram_we_n=1; SHALL capture sram_dq_in into read_data[15:0] (LOW) or read_data[31:16] (HIGH) on the last cycle of the half.
REQ-022 DONE: SHALL last one cycle with ready=1, then go to IDLE unconditionally; the still-asserted request in DONE SHALL NOT start a new access.
REQ-023 ready SHALL be combinational: 1 in DONE, or in IDLE with wr_en=0 and rd_en=0; 0 otherwise, including the IDLE cycle in which a request appears.
REQ-024 Latency: request first seen in cycle 0 -> ready=0 for cycles 0..2*HALF_CYCLES, ready=1 in cycle 2*HALF_CYCLES+1 (cycle 5 at default).
REQ-025 read_data SHALL change only during read captures and SHALL hold its value across writes and idle cycles.
REQ-026 Outside LOW/HIGH: sram_we_n=1, sram_dq_oe=0, sram_dq_out=0, sram_addr=0.
REQ-027 Changes on address, write_data, wr_en or rd_en after latching SHALL NOT affect an access in progress.

Reset
REQ-028 rst=0 SHALL force: state IDLE, counter 0, read_data 0, latched address/data/op 0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
REQ-029 rst=0 mid-access SHALL abort the access immediately (sram_we_n rises without waiting for clk); the partial halfword is not retried.
REQ-030 After rst rises, the first rising edge with a request SHALL start a fresh access from IDLE.

Verification
REQ-031 Idle: rst=1, wr_en=rd_en=0 for 10 cycles -> ready=1, sram_we_n=1, sram_dq_oe=0 throughout.
REQ-032 Write address=1024, data=0xDEADBEEF -> sram_addr=0 with dq_out=0xBEEF for 2 cycles, then sram_addr=1 with dq_out=0xDEAD for 2 cycles, we_n=0 in all four; ready=0 cycles 0..4, 1 in cycle 5.
REQ-033 Read address=1024, SRAM model returns 0xBEEF at addr 0 and 0xDEAD at addr 1 -> read_data=0xDEADBEEF in DONE cycle; ready pattern as REQ-032.
REQ-034 Write address=1028 with wr_en=rd_en=1, data=0x12345678 -> treated as write: sram_addr 2 gets 0x5678, addr 3 gets 0x1234; read_data unchanged.
REQ-035 rst=0 in cycle 2 of a write -> same-instant we_n=1, dq_oe=0, state IDLE, read_data=0; after rst=1, a read of 1024 completes in 6 cycles.
REQ-036 HALF_CYCLES=1 build, back-to-back reads of 1024 and 1028 -> each takes ready=0 for 3 cycles then ready=1 for 1 cycle, with no access started in DONE.
